// File: rtl/seqdet_pkg.sv
// seqdet_pkg: shared constants, match-mode encoding and a width helper for the
// programmable sequence detector.
//   DEF_PATTERN / DEF_LEN / DEF_OVERLAP : configuration loaded on reset
//   mode_e                              : MODE_NONOVL (0) / MODE_OVL (1)
//   clog2(v)                            : bits needed to index v values
package seqdet_pkg;

  localparam logic [7:0]  DEF_PATTERN = 8'b0010_1011;
  localparam int unsigned DEF_LEN     = 6;
  localparam bit          DEF_OVERLAP = 1'b1;

  typedef enum logic {
    MODE_NONOVL = 1'b0,
    MODE_OVL    = 1'b1
  } mode_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seqdet_sat_counter.sv
// seqdet_sat_counter: saturating up-counter with synchronous clear.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   clear        : synchronous clear; clear together with inc yields 1
//   inc          : count one event, holds at all-ones
//   count        : current value
module seqdet_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = inc ? CNT_W'(1) : '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/seq_detect_prog.sv
// seq_detect_prog: runtime-programmable serial bit-sequence detector.
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   sequence_in/in_valid: serial bit, sampled only while in_valid is high
//   cfg_load            : strobe loading cfg_pattern (right-aligned, bit
//                         cfg_len-1 arrives first), cfg_len, cfg_overlap
//   cnt_clear           : synchronous clear of match_count
//   detector_out        : registered one-cycle match pulse
//   match_count         : saturating number of matches
//   armed               : next valid bit can complete a match
module seq_detect_prog #(
  parameter int unsigned        MAX_LEN     = 8,
  parameter int unsigned        CNT_W       = 16,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(seqdet_pkg::DEF_PATTERN),
  parameter int unsigned        DEF_LEN     = seqdet_pkg::DEF_LEN,
  parameter bit                 DEF_OVERLAP = seqdet_pkg::DEF_OVERLAP
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   sequence_in,
  input  logic                                   in_valid,
  input  logic                                   cfg_load,
  input  logic [MAX_LEN-1:0]                     cfg_pattern,
  input  logic [seqdet_pkg::clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic                                   cfg_overlap,
  input  logic                                   cnt_clear,
  output logic                                   detector_out,
  output logic [CNT_W-1:0]                       match_count,
  output logic                                   armed
);

  import seqdet_pkg::*;

  localparam int unsigned     LW        = clog2(MAX_LEN + 1);
  localparam logic [LW-1:0]   MAX_LEN_L = LW'(MAX_LEN);

  logic [MAX_LEN-1:0] hist_q, hist_d, pat_q, pat_d;
  logic [MAX_LEN-1:0] nh, mask;
  logic [LW-1:0]      fill_q, fill_d, len_q, len_d, nf;
  mode_e              ovl_q, ovl_d;
  logic               det_q, det_d;
  logic               match;

  always_comb begin
    nh = {hist_q[MAX_LEN-2:0], sequence_in};
    nf = (fill_q >= MAX_LEN_L) ? MAX_LEN_L : fill_q + 1'b1;

    // Only the low len_q history bits take part in the compare.
    mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (LW'(i) < len_q) mask[i] = 1'b1;
    end

    match  = 1'b0;
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    det_d  = 1'b0;

    if (cfg_load) begin
      // A valid bit arriving with the load strobe is dropped.
      pat_d = cfg_pattern;
      ovl_d = mode_e'(cfg_overlap);
      if (cfg_len > MAX_LEN_L)  len_d = MAX_LEN_L;
      else if (cfg_len != '0)   len_d = cfg_len;
      fill_d = '0;
    end else if (in_valid) begin
      match  = (nf >= len_q) && (((nh ^ pat_q) & mask) == '0);
      hist_d = nh;
      fill_d = (match && (ovl_q == MODE_NONOVL)) ? '0 : nf;
      det_d  = match;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= DEF_PATTERN;
      len_q  <= LW'(DEF_LEN);
      ovl_q  <= mode_e'(DEF_OVERLAP);
      det_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      det_q  <= det_d;
    end
  end

  seqdet_sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clock (clock),
    .reset (reset),
    .clear (cnt_clear),
    .inc   (match),
    .count (match_count)
  );

  assign detector_out = det_q;
  // Extra bit keeps fill+1 from wrapping when MAX_LEN fills the LW range.
  assign armed = ({1'b0, fill_q} + 1'b1) >= {1'b0, len_q};

endmodule

// File: tb/tb_seq_detect_prog.sv
module tb_seq_detect_prog;

  logic       clock = 1'b0;
  logic       reset;
  logic       sequence_in, in_valid, cfg_load, cfg_overlap, cnt_clear;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       detector_out, armed;
  logic [3:0] match_count;

  int total = 0;
  int bad   = 0;

  // Reference model: list of bits received since the last restart point.
  bit         mq[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  int         m_cnt;
  bit         m_det;

  seq_detect_prog #(
    .MAX_LEN (8),
    .CNT_W   (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .sequence_in  (sequence_in),
    .in_valid     (in_valid),
    .cfg_load     (cfg_load),
    .cfg_pattern  (cfg_pattern),
    .cfg_len      (cfg_len),
    .cfg_overlap  (cfg_overlap),
    .cnt_clear    (cnt_clear),
    .detector_out (detector_out),
    .match_count  (match_count),
    .armed        (armed)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  task automatic model_reset();
    mq.delete();
    m_pat = 8'b0010_1011;
    m_len = 6;
    m_ovl = 1'b1;
    m_cnt = 0;
    m_det = 1'b0;
  endtask

  function automatic bit model_hit();
    if (mq.size() < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++)
      if (mq[mq.size() - m_len + k] != m_pat[m_len - 1 - k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit model_armed();
    return (mq.size() + 1) >= m_len;
  endfunction

  task automatic drive(input bit v, input bit b, input bit ld, input logic [7:0] p,
                       input logic [3:0] l, input bit o, input bit clr);
    bit hit;
    in_valid = v; sequence_in = b; cfg_load = ld;
    cfg_pattern = p; cfg_len = l; cfg_overlap = o; cnt_clear = clr;
    @(posedge clock);
    hit = 1'b0;
    if (ld) begin
      m_pat = p;
      m_ovl = o;
      if (l != 0) m_len = (l > 8) ? 8 : int'(l);
      mq.delete();
      m_det = 1'b0;
    end else if (v) begin
      mq.push_back(b);
      if (mq.size() > 8) void'(mq.pop_front());
      hit   = model_hit();
      m_det = hit;
      if (hit && !m_ovl) mq.delete();
    end else begin
      m_det = 1'b0;
    end
    if (clr)                    m_cnt = hit ? 1 : 0;
    else if (hit && m_cnt < 15) m_cnt++;
    #1;
  endtask

  task automatic send(input bit b);
    drive(1'b1, b, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 0; sequence_in = 0; cfg_load = 0; cfg_pattern = 0;
    cfg_len = 0; cfg_overlap = 0; cnt_clear = 0;
    #12;
    total++;
    if ({detector_out, armed, match_count} !== 6'b0) begin
      bad++;
      $display("FAIL reset_state got=%b want=000000", {detector_out, armed, match_count});
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_defaults();
    logic [5:0] s = 6'b101011;
    for (int i = 0; i < 6; i++) begin
      send(s[5-i]);
      total++;
      if ({detector_out, armed, match_count} !== {m_det, model_armed(), 4'(m_cnt)}) begin
        bad++;
        $display("FAIL defaults_model bit%0d got=%b want=%b", i,
                 {detector_out, armed, match_count}, {m_det, model_armed(), 4'(m_cnt)});
      end
      total++;
      if (detector_out !== (i == 5) || armed !== (i >= 4)) begin
        bad++;
        $display("FAIL defaults_pulse bit%0d got det=%b armed=%b want det=%b armed=%b",
                 i, detector_out, armed, i == 5, i >= 4);
      end
    end
    idle();
    total++;
    if (detector_out !== 1'b0 || match_count !== 4'd1) begin
      bad++;
      $display("FAIL defaults_after got det=%b cnt=%0d want det=0 cnt=1", detector_out, match_count);
    end
  endtask

  task automatic test_program_modes();
    logic [6:0] a = 7'b1010101;
    logic [7:0] c = 8'b10101010;
    drive(1'b0, 1'b0, 1'b1, 8'b0000_1010, 4'd4, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      send(a[6-i]);
      total++;
      if (detector_out !== (i == 3 || i == 5) || detector_out !== m_det) begin
        bad++;
        $display("FAIL ovl_pulse bit%0d got=%b want=%b", i, detector_out, i == 3 || i == 5);
      end
    end
    total++;
    if (match_count !== 4'd2) begin
      bad++;
      $display("FAIL ovl_count got=%0d want=2", match_count);
    end
    drive(1'b0, 1'b0, 1'b1, 8'b0000_1010, 4'd4, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      send(c[7-i]);
      total++;
      if (detector_out !== (i == 3 || i == 7) || detector_out !== m_det) begin
        bad++;
        $display("FAIL nonovl_pulse bit%0d got=%b want=%b", i, detector_out, i == 3 || i == 7);
      end
    end
    total++;
    if (match_count !== 4'd2) begin
      bad++;
      $display("FAIL nonovl_count got=%0d want=2", match_count);
    end
  endtask

  task automatic test_idle_gaps();
    logic [5:0] s = 6'b101011;
    drive(1'b0, 1'b0, 1'b1, 8'b0010_1011, 4'd6, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      send(s[5-i]);
      total++;
      if (detector_out !== (i == 5) || {armed, match_count} !== {model_armed(), 4'(m_cnt)}) begin
        bad++;
        $display("FAIL gaps_bit bit%0d got det=%b armed=%b cnt=%0d want det=%b armed=%b cnt=%0d",
                 i, detector_out, armed, match_count, i == 5, model_armed(), m_cnt);
      end
      for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
        idle();
        total++;
        if (detector_out !== 1'b0) begin
          bad++;
          $display("FAIL gaps_idle bit%0d got=%b want=0", i, detector_out);
        end
      end
    end
  endtask

  task automatic test_cfg_collision();
    logic [3:0] h = 4'b1010;
    logic [5:0] s = 6'b101011;
    for (int i = 0; i < 4; i++) send(h[3-i]);
    drive(1'b1, 1'b1, 1'b1, 8'b0010_1011, 4'd6, 1'b1, 1'b0);
    total++;
    if (armed !== 1'b0 || detector_out !== 1'b0) begin
      bad++;
      $display("FAIL collide_load got armed=%b det=%b want armed=0 det=0", armed, detector_out);
    end
    for (int i = 0; i < 2; i++) begin
      send(1'b1);
      total++;
      if (detector_out !== 1'b0 || detector_out !== m_det) begin
        bad++;
        $display("FAIL collide_tail bit%0d got=%b want=0", i, detector_out);
      end
    end
    for (int i = 0; i < 6; i++) begin
      send(s[5-i]);
      total++;
      if (detector_out !== (i == 5) || detector_out !== m_det) begin
        bad++;
        $display("FAIL collide_full bit%0d got=%b want=%b", i, detector_out, i == 5);
      end
    end
  endtask

  task automatic test_saturation();
    drive(1'b0, 1'b0, 1'b1, 8'b0000_0001, 4'd1, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      send(1'b1);
      total++;
      if ({detector_out, match_count} !== {1'b1, 4'(m_cnt)}) begin
        bad++;
        $display("FAIL sat_step bit%0d got det=%b cnt=%0d want det=1 cnt=%0d",
                 i, detector_out, match_count, m_cnt);
      end
    end
    total++;
    if (match_count !== 4'd15) begin
      bad++;
      $display("FAIL sat_hold got=%0d want=15", match_count);
    end
    drive(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
    total++;
    if (match_count !== 4'd1) begin
      bad++;
      $display("FAIL clear_with_match got=%0d want=1", match_count);
    end
    drive(1'b0, 1'b0, 1'b1, 8'b0000_0001, 4'd1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send(1'b1);
      total++;
      if (detector_out !== 1'b1 || armed !== 1'b1 || match_count !== 4'(m_cnt)) begin
        bad++;
        $display("FAIL len1_nonovl bit%0d got det=%b armed=%b cnt=%0d want det=1 armed=1 cnt=%0d",
                 i, detector_out, armed, match_count, m_cnt);
      end
    end
  endtask

  task automatic test_len_cfg();
    logic [3:0] p4 = 4'b1001;
    logic [7:0] p8 = 8'b1010_0101;
    drive(1'b0, 1'b0, 1'b1, 8'b0000_0110, 4'd4, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 8'b0000_1001, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send(p4[3-i]);
      total++;
      if (detector_out !== (i == 3) || armed !== (i >= 2)) begin
        bad++;
        $display("FAIL len0_keep bit%0d got det=%b armed=%b want det=%b armed=%b",
                 i, detector_out, armed, i == 3, i >= 2);
      end
    end
    drive(1'b0, 1'b0, 1'b1, 8'b1010_0101, 4'd12, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      send(p8[7-i]);
      total++;
      if (detector_out !== (i == 7) || armed !== (i >= 6)) begin
        bad++;
        $display("FAIL len12_clamp bit%0d got det=%b armed=%b want det=%b armed=%b",
                 i, detector_out, armed, i == 7, i >= 6);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] pre  = 5'b10101;
    logic [4:0] rest = 5'b01011;
    drive(1'b0, 1'b0, 1'b1, 8'b0000_0110, 4'd4, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send(pre[4-i]);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({detector_out, armed, match_count} !== 6'b0) begin
      bad++;
      $display("FAIL async_reset got=%b want=000000", {detector_out, armed, match_count});
    end
    #2;
    reset = 1'b0;
    model_reset();
    send(1'b1);
    total++;
    if (detector_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_pulse got=%b want=0", detector_out);
    end
    for (int i = 0; i < 5; i++) begin
      send(rest[4-i]);
      total++;
      if (detector_out !== (i == 4) || detector_out !== m_det) begin
        bad++;
        $display("FAIL reset_default_pat bit%0d got=%b want=%b", i, detector_out, i == 4);
      end
    end
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 5)
        drive(1'b0, 1'($urandom), 1'b1, 8'($urandom),
              (r < 2) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 3)),
              1'($urandom), 1'($urandom));
      else if (r < 8)
        drive(1'($urandom), 1'($urandom), 1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
      else
        drive(r < 85, 1'($urandom), 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
      total++;
      if ({detector_out, armed, match_count} !== {m_det, model_armed(), 4'(m_cnt)}) begin
        bad++;
        $display("FAIL random step%0d got=%b want=%b", n,
                 {detector_out, armed, match_count}, {m_det, model_armed(), 4'(m_cnt)});
      end
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_program_modes();
    test_idle_gaps();
    test_cfg_collision();
    test_saturation();
    test_len_cfg();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_detect_prog.md
Name: seq_detect_prog

Overview:
- Parametrised, runtime-programmable serial bit-sequence detector. Successor to the team's fixed-pattern "101011" Mealy detector.
- Adds:
  - pattern and length loadable at run time, up to MAX_LEN bits;
  - overlap / non-overlap match mode;
  - input-valid qualification;
  - saturating match counter.
- Sits on a serial data path, after the bit deserialiser or line receiver. The detect pulse feeds framing and sync logic. The counter is read by status software.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- CNT_W, 16, width of the match counter.
- DEF_PATTERN, 8'b0010_1011, reset pattern (MAX_LEN bits, right-aligned).
- DEF_LEN, 6, reset pattern length (1..MAX_LEN).
- DEF_OVERLAP, 1, reset match mode (1 = overlapping).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- sequence_in  in  1  serial data bit.
- in_valid  in  1  sequence_in is sampled only when high.
- cfg_load  in  1  one-cycle strobe: load cfg_pattern, cfg_len and cfg_overlap.
- cfg_pattern  in  MAX_LEN  new pattern, right-aligned; bit cfg_len-1 is the first bit received.
- cfg_len  in  clog2(MAX_LEN+1)  new pattern length.
- cfg_overlap  in  1  new match mode.
- cnt_clear  in  1  synchronous clear of match_count.
- detector_out  out  1  one-cycle registered match pulse.
- match_count  out  CNT_W  saturating count of matches.
- armed  out  1  fill count >= active length - 1, i.e. the next valid bit can complete a match.

Behaviour:
- Reset (asynchronous):
  - detector_out=0, match_count=0, armed=0;
  - history=0, fill=0;
  - pattern=DEF_PATTERN, length=DEF_LEN, mode=DEF_OVERLAP.
- State:
  - hist[MAX_LEN-1:0] shift register;
  - fill counter, 0..MAX_LEN, saturating;
  - pat_q, len_q, ovl_q.
- Valid bit, in_valid=1 and cfg_load=0:
  - nh = {hist[MAX_LEN-2:0], sequence_in};
  - nf = min(fill+1, MAX_LEN);
  - match = (nf >= len_q) && (nh[len_q-1:0] == pat_q[len_q-1:0]);
  - hist <= nh.
  - Non-overlap mode with match: fill <= 0. Otherwise fill <= nf.
- Latency: detector_out <= match at the same edge that samples the final pattern bit. The pulse is visible in the following cycle and lasts exactly one cycle.
- Cycles with in_valid=0:
  - hist and fill hold;
  - detector_out <= 0.
- cfg_load=1:
  - loads pat_q, ovl_q and len_q;
  - cfg_len > MAX_LEN clamps to MAX_LEN;
  - cfg_len = 0 leaves len_q unchanged, while pattern and mode still load;
  - clears fill to 0 and detector_out to 0.
  - Same cycle as in_valid: cfg_load wins and the bit is dropped.
  - match_count is not affected.
- match_count:
  - increments on each match and saturates at all-ones;
  - cnt_clear alone sets it to 0;
  - cnt_clear and match in the same cycle gives 1.
- armed: combinational from fill and len_q, i.e. fill >= len_q-1.
- Reset mid-pattern: all partial progress is lost immediately. Configuration reverts to defaults.
- len_q=1: every valid bit equal to pat_q[0] matches. In non-overlap mode fill toggles 0→0.

Decomposition:
- Package seqdet_pkg holds:
  - DEF_* constants;
  - length-width function clog2;
  - mode encoding constants MODE_NONOVL=0 and MODE_OVL=1.
- Sub-module seqdet_sat_counter (CNT_W) implements increment, clear and saturate with clear+inc=1. It is reusable by other status counters.
- The top level holds config registers, history/fill and the compare.

Test Plan:
1. Defaults (101011, overlap). Send 1,0,1,0,1,1 with in_valid=1 → detector_out=1 in the cycle after the 6th bit only; match_count=1; armed=1 after the 5th bit.
2. Load pattern 1010, len 4, overlap=1. Send 1010101 → pulses after bits 4 and 6, match_count=2. Repeat with overlap=0 on 10101010 → pulses after bits 4 and 8 only.
3. Defaults, with in_valid=0 for 1-3 random cycles between bits of 101011 → single pulse after the last valid bit; detector_out=0 on all idle cycles.
4. Send 1010 of 101011, pulse cfg_load (same pattern) together with in_valid=1 → that bit dropped, fill=0; following 11 gives no pulse; a full 101011 afterwards gives a pulse.
5. CNT_W=4: 20 matches → match_count holds 15. Assert cnt_clear on a match cycle → 1. cfg_len=0 load → len_q unchanged. cfg_len=12 → len_q=8.
6. Assert reset asynchronously after 10101 → outputs 0 before the next edge. A following 1 gives no pulse, and the pattern is back to 101011.
